rect_fill: RTL and testbench
============================

// Module: rect_fill
// PURPOSE
//  Parametrised successor to the full-screen black fill: plots an axis-aligned rectangle (solid or outline)
//  of any colour into the VGA adapter framebuffer, one pixel per clock.
//  Corners may be given in any order and are clipped to the screen.
//  Sits between the top-level sequencer and the VGA adapter (drives vga_x/vga_y/vga_colour/vga_plot),
//  alongside the circle/Reuleaux drawers; a top-level mux selects which engine owns the VGA port.
// PARAMETERS
//  SCREEN_W  160  visible columns; x range 0..SCREEN_W-1
//  SCREEN_H  120  visible rows; y range 0..SCREEN_H-1
//  XW        8    x coordinate width
//  YW        7    y coordinate width
//  CW        3    colour width
// PORTS
//  clk         in   1   single clock; all state on rising edge
//  rst         in   1   asynchronous, active-high reset
//  start       in   1   request; held high by master until done seen
//  x0,x1       in   XW  corner columns (inclusive, any order)
//  y0,y1       in   YW  corner rows (inclusive, any order)
//  colour      in   CW  plot colour
//  outline     in   1   0 = solid fill, 1 = one-pixel border only
//  done        out  1   operation complete; held while start high
//  vga_x       out  XW  pixel column
//  vga_y       out  YW  pixel row
//  vga_colour  out  CW  pixel colour
//  vga_plot    out  1   write strobe, one pixel per asserted cycle
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, done=0, vga_plot=0, vga_x=0, vga_y=0, vga_colour=0.
//  States: IDLE -> SETUP -> PLOT -> DONE -> IDLE.
//  - IDLE: on start=1 at a clock edge, latch x0..y1, colour and outline; go to SETUP.
//  - SETUP (1 cycle): normalise to xlo<=xhi, ylo<=yhi.
//    Clip xhi to SCREEN_W-1 and yhi to SCREEN_H-1.
//    If xlo>=SCREEN_W or ylo>=SCREEN_H (fully off-screen), go straight to DONE; zero plots.
//    Otherwise load cx=xlo, cy=ylo and go to PLOT.
//  - PLOT: vga_plot=1 every cycle; vga_x=cx, vga_y=cy, vga_colour=latched colour.
//    Scan is column-major: cy steps from ylo to yhi; on cy==yhi, cy reloads ylo and cx increments.
//    Leaving PLOT: after the pixel (xhi,yhi), go to DONE.
//    Outline mode: on interior columns (xlo<cx<xhi), cy jumps ylo->yhi, skipping interior rows.
//    Solid count = W*H cycles. Outline count = 2H + 2(W-2) for W,H>=2.
//    Degenerate cases (W==1 or H==1 or both): each pixel is plotted exactly once, never twice.
//  - DONE: done=1, vga_plot=0. Stay while start=1; start=0 returns to IDLE, done falls the next cycle.
//  Latency: start sampled at edge 0; first pixel valid in the cycle after edge 1;
//    done rises the cycle after the last pixel.
//  Inputs and start deassertion during SETUP/PLOT are ignored; the latched job runs to completion.
//  A new job requires start low then high again.
//  vga_plot=0 in IDLE/SETUP/DONE; vga_x/vga_y hold their last value there.
//  Counter arithmetic is XW/YW wide; clipping guarantees cx<=SCREEN_W-1, so no wrap occurs.
// STRUCTURE
//  Package rect_pkg:
//   - state enum {IDLE,SETUP,PLOT,DONE}
//   - SCREEN_W/SCREEN_H defaults
//   - colour constants BLACK=3'b000, GREEN=3'b010, WHITE=3'b111
//  Sub-module rect_clip (combinational): swaps and clips corners, outputs xlo/xhi/ylo/yhi and an offscreen flag.
//  The FSM and counters live in rect_fill.
// TESTING
//  1 Full screen (0,0)-(159,119), GREEN, solid:
//    19200 plots, first (0,0), then (0,1); 120th plot (0,119), 121st (1,0); last (159,119);
//    done the next cycle.
//  2 Swapped corners (10,20)-(7,18), WHITE, solid:
//    12 plots, x 7..10 by y 18..20, column-major; identical to (7,18)-(10,20).
//  3 Clipped (150,110)-(200,126), solid:
//    100 plots, x 150..159, y 110..119; no plot with x>159 or y>119.
//  4 Off-screen (170,5)-(180,9):
//    zero plots; done high 2 cycles after start is sampled.
//  5 Outline (2,3)-(5,5):
//    10 distinct plots, none at (3,4) or (4,4).
//    Outline (4,4)-(4,4): exactly 1 plot.
//    Outline (0,0)-(3,0): 4 plots.
//  6 Assert rst mid-PLOT:
//    vga_plot=0 and done=0 immediately (before next edge), state IDLE.
//    Start held high -> job restarts from the first pixel.
//    In DONE with start held: done stays 1; start low -> done 0 one cycle later.

Source files
------------

// File: rtl/rect_pkg.sv
// rect_pkg: shared FSM state type, screen geometry defaults and colour constants for rect_fill
package rect_pkg;

    typedef enum logic [1:0] {IDLE, SETUP, PLOT, DONE} state_t;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    localparam logic [2:0] BLACK = 3'b000;
    localparam logic [2:0] GREEN = 3'b010;
    localparam logic [2:0] WHITE = 3'b111;

endpackage

// File: rtl/rect_clip.sv
// rect_clip: orders two corners into lo/hi, clips hi to the screen edge and flags fully off-screen rectangles
// Ports: x0,x1,y0,y1 raw corners in; xlo,xhi,ylo,yhi normalised and clipped bounds out; offscreen out
module rect_clip
    import rect_pkg::*;
#(
    parameter int SW = SCREEN_W,
    parameter int SH = SCREEN_H,
    parameter int XW = 8,
    parameter int YW = 7
) (
    input  logic [XW-1:0] x0,
    input  logic [XW-1:0] x1,
    input  logic [YW-1:0] y0,
    input  logic [YW-1:0] y1,
    output logic [XW-1:0] xlo,
    output logic [XW-1:0] xhi,
    output logic [YW-1:0] ylo,
    output logic [YW-1:0] yhi,
    output logic          offscreen
);

    localparam logic [XW-1:0] XMAX = XW'(SW - 1);
    localparam logic [YW-1:0] YMAX = YW'(SH - 1);

    logic [XW-1:0] xmx;
    logic [YW-1:0] ymx;

    always_comb begin
        xlo       = x0 < x1 ? x0 : x1;
        xmx       = x0 < x1 ? x1 : x0;
        ylo       = y0 < y1 ? y0 : y1;
        ymx       = y0 < y1 ? y1 : y0;
        xhi       = xmx > XMAX ? XMAX : xmx;
        yhi       = ymx > YMAX ? YMAX : ymx;
        offscreen = xlo > XMAX || ylo > YMAX;
    end

endmodule

// File: rtl/rect_fill.sv
// rect_fill: plots a clipped solid or outlined rectangle into the VGA framebuffer, one pixel per clock
// Ports: clk, rst (async active-high); start/done handshake; x0,x1,y0,y1 corners, colour, outline job inputs;
//        vga_x, vga_y, vga_colour, vga_plot pixel write port
module rect_fill
    import rect_pkg::*;
#(
    parameter int SCREEN_W = rect_pkg::SCREEN_W,
    parameter int SCREEN_H = rect_pkg::SCREEN_H,
    parameter int XW       = 8,
    parameter int YW       = 7,
    parameter int CW       = 3
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [XW-1:0] x0,
    input  logic [XW-1:0] x1,
    input  logic [YW-1:0] y0,
    input  logic [YW-1:0] y1,
    input  logic [CW-1:0] colour,
    input  logic          outline,
    output logic          done,
    output logic [XW-1:0] vga_x,
    output logic [YW-1:0] vga_y,
    output logic [CW-1:0] vga_colour,
    output logic          vga_plot
);

    state_t        state;
    logic [XW-1:0] lx0, lx1, xlo, xhi;
    logic [YW-1:0] ly0, ly1, ylo, yhi;
    logic [CW-1:0] lcol;
    logic          lout, offscreen, last, skip;

    // Bounds are derived from the latched corners, so they stay stable for the whole job.
    rect_clip #(.SW(SCREEN_W), .SH(SCREEN_H), .XW(XW), .YW(YW)) u_clip (
        .x0(lx0), .x1(lx1), .y0(ly0), .y1(ly1),
        .xlo(xlo), .xhi(xhi), .ylo(ylo), .yhi(yhi),
        .offscreen(offscreen)
    );

    // vga_x/vga_y double as the scan counters cx/cy.
    assign last = vga_x == xhi && vga_y == yhi;
    // Interior outline columns only need their top and bottom pixel.
    assign skip = lout && vga_x > xlo && vga_x < xhi;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            done       <= 1'b0;
            vga_plot   <= 1'b0;
            vga_x      <= '0;
            vga_y      <= '0;
            vga_colour <= '0;
            lx0        <= '0;
            lx1        <= '0;
            ly0        <= '0;
            ly1        <= '0;
            lcol       <= '0;
            lout       <= 1'b0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    lx0   <= x0;
                    lx1   <= x1;
                    ly0   <= y0;
                    ly1   <= y1;
                    lcol  <= colour;
                    lout  <= outline;
                    state <= SETUP;
                end
                SETUP: if (offscreen) begin
                    done  <= 1'b1;
                    state <= DONE;
                end else begin
                    vga_x      <= xlo;
                    vga_y      <= ylo;
                    vga_colour <= lcol;
                    vga_plot   <= 1'b1;
                    state      <= PLOT;
                end
                PLOT: if (last) begin
                    vga_plot <= 1'b0;
                    done     <= 1'b1;
                    state    <= DONE;
                end else if (vga_y == yhi) begin
                    vga_x <= vga_x + 1'b1;
                    vga_y <= ylo;
                end else begin
                    vga_y <= skip ? yhi : vga_y + 1'b1;
                end
                DONE: if (!start) begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rect_fill.sv
// tb_rect_fill: directed self-checking bench for rect_fill
module tb_rect_fill;
    import rect_pkg::*;

    logic       clk = 1'b0, rst = 1'b1, start = 1'b0, outline = 1'b0;
    logic [7:0] x0 = '0, x1 = '0;
    logic [6:0] y0 = '0, y1 = '0;
    logic [2:0] colour = '0;
    logic       done, vga_plot;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;

    rect_fill dut (
        .clk(clk), .rst(rst), .start(start),
        .x0(x0), .x1(x1), .y0(y0), .y1(y1),
        .colour(colour), .outline(outline),
        .done(done), .vga_x(vga_x), .vga_y(vga_y),
        .vga_colour(vga_colour), .vga_plot(vga_plot)
    );

    always #5 clk = ~clk;

    typedef struct {int x; int y; int c;} pix_t;
    pix_t pq[$];
    int   checks = 0, failures = 0, first_n, done_n;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic chk_pix(input string tag, input int i, input int ex, input int ey);
        check(tag, i < pq.size() ? pq[i].x * 256 + pq[i].y : -1, ex * 256 + ey);
    endtask

    function automatic int dups();
        bit seen[256][128];
        int n = 0;
        foreach (pq[i]) begin
            if (seen[pq[i].x][pq[i].y]) n++;
            seen[pq[i].x][pq[i].y] = 1'b1;
        end
        return n;
    endfunction

    function automatic int hits(input int x, input int y);
        int n = 0;
        foreach (pq[i]) if (pq[i].x == x && pq[i].y == y) n++;
        return n;
    endfunction

    // Expects start to have just been raised at a falling edge; collects plots until done.
    task automatic wait_job();
        pq.delete();
        first_n = -1;
        done_n  = -1;
        for (int n = 1; n < 25000 && done_n < 0; n++) begin
            @(negedge clk);
            if (vga_plot) begin
                if (first_n < 0) first_n = n;
                pq.push_back('{int'(vga_x), int'(vga_y), int'(vga_colour)});
            end
            if (done) done_n = n;
        end
        check("timeout", done_n > 0, 1);
        check("done_lat", done_n, pq.size() + 2);
    endtask

    task automatic run(input int ax0, input int ay0, input int ax1, input int ay1,
                       input logic [2:0] c, input logic o);
        x0 = 8'(ax0); y0 = 7'(ay0); x1 = 8'(ax1); y1 = 7'(ay1);
        colour = c; outline = o; start = 1'b1;
        wait_job();
        start = 1'b0;
        @(negedge clk);
        check("done_fall", done, 0);
    endtask

    initial begin
        int bad, k;
        repeat (2) @(negedge clk);
        check("rst_done", done, 0);
        check("rst_plot", vga_plot, 0);
        check("rst_xy", {vga_x, vga_y}, 0);
        check("rst_col", vga_colour, 0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_plot", vga_plot, 0);

        run(0, 0, 159, 119, GREEN, 1'b0);
        check("full_cnt", pq.size(), 19200);
        check("full_first_n", first_n, 2);
        chk_pix("full_p0", 0, 0, 0);
        chk_pix("full_p1", 1, 0, 1);
        chk_pix("full_p119", 119, 0, 119);
        chk_pix("full_p120", 120, 1, 0);
        chk_pix("full_last", 19199, 159, 119);
        check("full_col", pq.size() > 0 ? pq[0].c : -1, 2);

        run(10, 20, 7, 18, WHITE, 1'b0);
        check("swap_cnt", pq.size(), 12);
        bad = 0; k = 0;
        for (int x = 7; x <= 10; x++)
            for (int y = 18; y <= 20; y++) begin
                if (k >= pq.size() || pq[k].x != x || pq[k].y != y || pq[k].c != 7) bad++;
                k++;
            end
        check("swap_seq", bad, 0);
        chk_pix("swap_hold", 11, 10, 20);
        check("swap_holdxy", {vga_x, vga_y}, {8'd10, 7'd20});

        run(150, 110, 200, 126, BLACK, 1'b0);
        check("clip_cnt", pq.size(), 100);
        bad = 0;
        foreach (pq[i]) if (pq[i].x < 150 || pq[i].x > 159 || pq[i].y < 110 || pq[i].y > 119) bad++;
        check("clip_range", bad, 0);
        check("clip_dups", dups(), 0);
        chk_pix("clip_first", 0, 150, 110);
        chk_pix("clip_last", 99, 159, 119);

        run(170, 5, 180, 9, WHITE, 1'b0);
        check("off_cnt", pq.size(), 0);
        check("off_done_n", done_n, 2);

        run(2, 3, 5, 5, GREEN, 1'b1);
        check("ol_cnt", pq.size(), 10);
        check("ol_dups", dups(), 0);
        check("ol_34", hits(3, 4), 0);
        check("ol_44", hits(4, 4), 0);
        check("ol_35", hits(3, 5), 1);
        run(4, 4, 4, 4, GREEN, 1'b1);
        check("ol_dot_cnt", pq.size(), 1);
        chk_pix("ol_dot", 0, 4, 4);
        run(0, 0, 3, 0, GREEN, 1'b1);
        check("ol_row_cnt", pq.size(), 4);
        check("ol_row_dups", dups(), 0);
        chk_pix("ol_row_last", 3, 3, 0);

        x0 = 8'd2; y0 = 7'd3; x1 = 8'd5; y1 = 7'd5; outline = 1'b0; colour = WHITE;
        start = 1'b1;
        repeat (5) @(negedge clk);
        check("pre_rst_plot", vga_plot, 1);
        rst = 1'b1;
        #1;
        check("mid_rst_plot", vga_plot, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_xy", {vga_x, vga_y}, 0);
        @(negedge clk);
        rst = 1'b0;
        wait_job();
        check("restart_cnt", pq.size(), 12);
        chk_pix("restart_first", 0, 2, 3);
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (done !== 1'b1 || vga_plot !== 1'b0) bad++;
        end
        check("done_hold", bad, 0);
        start = 1'b0;
        check("done_before_edge", done, 1);
        @(negedge clk);
        check("done_drop", done, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
